scr1_dmem_initiator: RTL and testbench
======================================

Name: scr1_dmem_initiator

Overview:
Single-outstanding initiator on the SCR1 dmem interface. It converts a valid/ready client command stream into dmem request/ack/response transactions and returns the result on a valid/ready response port. It is used by non-core masters, such as the debug/test harness and the future DMA, to reach memory-mapped slaves like the timer, TCM and IPIC. Misaligned commands are rejected locally and never reach the bus.

Parameters:
TIMEOUT_CYCLES, 256, cycles spent in WAIT_RESP before a forced error response; legal range 1..65535; used only when the optional feature is compiled in.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  client command valid
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_width  in  type_scr1_mem_width_e  access width
cmd_addr  in  `SCR1_DMEM_AWIDTH  byte address
cmd_wdata  in  `SCR1_DMEM_DWIDTH  write data, passed unmodified
resp_valid  out  1  response valid
resp_ready  in  1  client accepts response
resp_rdata  out  `SCR1_DMEM_DWIDTH  read data: raw 32-bit bus word, no lane shift; 0 for writes and errors
resp_err  out  1  1 = bus error, misalignment or timeout
dmem_req  out  1  request to slave
dmem_cmd  out  type_scr1_mem_cmd_e  SCR1_MEM_CMD_RD / SCR1_MEM_CMD_WR
dmem_width  out  type_scr1_mem_width_e  access width
dmem_addr  out  `SCR1_DMEM_AWIDTH  address
dmem_wdata  out  `SCR1_DMEM_DWIDTH  write data
dmem_req_ack  in  1  slave accepted request
dmem_rdata  in  `SCR1_DMEM_DWIDTH  slave read data
dmem_resp  in  type_scr1_mem_resp_e  NOTRDY / RDY_OK / RDY_ER

Behaviour:
- FSM states: IDLE, REQ, WAIT_RESP, RESP_OUT. Reset state is IDLE.
- cmd_ready = (state == IDLE); it reads 1 while rst_n is low, but no flop changes during reset.
- IDLE + handshake:
  - Command fields are registered.
  - Misaligned command (HALFWORD with addr[0]=1, or WORD with addr[1:0]!=0): go to RESP_OUT with err=1, rdata=0, no dmem activity.
  - Otherwise: go to REQ.
- REQ:
  - dmem_req=1; dmem_cmd/width/addr/wdata are taken from the registered command and held stable until ack.
  - dmem_req_ack=1 moves to WAIT_RESP.
  - dmem_resp is ignored in REQ.
- WAIT_RESP:
  - dmem_req=0.
  - NOTRDY: stay.
  - RDY_OK: capture rdata (reads) or 0 (writes), err=0, go to RESP_OUT.
  - RDY_ER: rdata=0, err=1, go to RESP_OUT.
- RESP_OUT:
  - resp_valid=1, resp_rdata and resp_err stable.
  - resp_ready=1 moves to IDLE. No same-cycle acceptance of a new command.
- Minimum latency, accept to resp_valid: 3 cycles with a same-cycle ack and next-cycle response (timer-style slave). Throughput is one transaction per at least 4 cycles.
- Reset values: dmem_req=0, dmem_cmd=RD, dmem_width=WORD, dmem_addr=0, dmem_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0.
- dmem_req, cmd_ready and resp_valid are decoded from the state register only, with no combinational path from inputs.
- Reset mid-transaction: immediate return to IDLE; dmem_req drops asynchronously; the in-flight response is lost.
- A dmem_resp value outside the three legal encodings in WAIT_RESP is treated as RDY_ER.

Optional Feature:
SCR1_DMEM_INIT_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT_RESP and increments each WAIT_RESP cycle.
  - Reaching TIMEOUT_CYCLES forces RESP_OUT with err=1, rdata=0.
  - A real response arriving in the same cycle as the timeout wins.
  - Late responses arriving outside WAIT_RESP are ignored.
- Undefined: no counter; WAIT_RESP waits indefinitely.

Decomposition:
- The FSM state enum (type_scr1_dmem_init_fsm_e) goes in the shared package scr1_memif.svh alongside the existing mem cmd/width/resp types.
- An alignment-check function also goes in the package, for reuse by other masters.
- The timeout counter is a natural sub-module, scr1_dmem_init_tmo, instantiated only under the macro.
- Everything else stays flat.

Test Plan:
- Read 0x10 WORD; slave acks on the REQ cycle and returns RDY_OK with rdata=0x1234_5678 the next cycle → resp_valid 3 cycles after accept, resp_rdata=0x12345678, resp_err=0.
- Write 0x14 WORD, wdata=0xDEAD_BEEF; ack delayed 3 cycles → dmem_addr/wdata stable and dmem_req=1 for 4 cycles, then resp_err=0, resp_rdata=0.
- WORD read at 0x06 and HALFWORD at 0x03 → dmem_req never asserts; resp_err=1 one cycle after accept.
- Slave returns RDY_ER to a read at 0x20 → resp_err=1, resp_rdata=0; with resp_ready held 0 for 5 cycles, outputs stay stable and cmd_ready=0.
- rst_n pulsed low during WAIT_RESP → dmem_req=0, resp_valid=0, cmd_ready=1 immediately; a late RDY_OK after reset release produces no response.
- SCR1_DMEM_INIT_TIMEOUT_EN with TIMEOUT_CYCLES=8 and slave never responding → resp_err=1 exactly 8 cycles after entering WAIT_RESP; with RDY_OK on cycle 8 → resp_err=0.

Source files
------------

// File: rtl/scr1_dmem_initiator_pkg.sv
// -----------------------------------------------------------------------------
// scr1_dmem_initiator_pkg
// Shared definitions for the SCR1 dmem interface and the single-outstanding
// dmem initiator: bus widths, memory command/width/response encodings, the
// initiator FSM state type and an address alignment check that other bus
// masters can reuse.
// -----------------------------------------------------------------------------
package scr1_dmem_initiator_pkg;

  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  // 2'b11 is not a legal response; receivers treat it as an error.
  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    SCR1_DMEM_INIT_IDLE      = 2'b00,
    SCR1_DMEM_INIT_REQ       = 2'b01,
    SCR1_DMEM_INIT_WAIT_RESP = 2'b10,
    SCR1_DMEM_INIT_RESP_OUT  = 2'b11
  } type_scr1_dmem_init_fsm_e;

  // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes are always fine.
  function automatic logic scr1_mem_addr_misaligned(input type_scr1_mem_width_e width,
                                                    input logic [1:0]           addr_lsb);
    logic mis;
    mis = 1'b0;
    case (width)
      SCR1_MEM_WIDTH_HWORD: mis = addr_lsb[0];
      SCR1_MEM_WIDTH_WORD:  mis = (addr_lsb != 2'b00);
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/scr1_dmem_initiator_if.sv
// -----------------------------------------------------------------------------
// scr1_dmem_initiator_if
// SCR1 dmem request/ack/response bus.
//   master : drives dmem_req/cmd/width/addr/wdata, receives req_ack/rdata/resp
//   slave  : the opposite direction (memory-mapped target)
// -----------------------------------------------------------------------------
interface scr1_dmem_initiator_if;
  import scr1_dmem_initiator_pkg::*;

  logic                              dmem_req;
  type_scr1_mem_cmd_e                dmem_cmd;
  type_scr1_mem_width_e              dmem_width;
  logic [SCR1_DMEM_AWIDTH-1:0]       dmem_addr;
  logic [SCR1_DMEM_DWIDTH-1:0]       dmem_wdata;
  logic                              dmem_req_ack;
  logic [SCR1_DMEM_DWIDTH-1:0]       dmem_rdata;
  type_scr1_mem_resp_e               dmem_resp;

  modport master (
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    input  dmem_req_ack, dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    output dmem_req_ack, dmem_rdata, dmem_resp
  );

endinterface

// File: rtl/scr1_dmem_init_tmo.sv
// -----------------------------------------------------------------------------
// scr1_dmem_init_tmo
// Response timeout counter for scr1_dmem_initiator, compiled only when
// SCR1_DMEM_INIT_TIMEOUT_EN is defined.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : entering WAIT_RESP, restart the count
//   en         : currently in WAIT_RESP
//   expired    : this WAIT_RESP cycle is number TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
`ifdef SCR1_DMEM_INIT_TIMEOUT_EN
module scr1_dmem_init_tmo #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // cnt holds the number of WAIT_RESP cycles already completed.
  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expired = en && (cnt == LAST_CNT);

endmodule
`endif

// File: rtl/scr1_dmem_initiator.sv
// -----------------------------------------------------------------------------
// scr1_dmem_initiator
// Single-outstanding initiator on the SCR1 dmem bus for non-core masters.
// A valid/ready command becomes one dmem request/ack/response transaction and
// the result is returned on a valid/ready response port. Misaligned commands
// are answered locally with an error and never reach the bus.
//   clk, rst_n                        : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready               : command handshake
//   cmd_write/width/addr/wdata        : command fields
//   resp_valid/resp_ready             : response handshake
//   resp_rdata/resp_err               : raw read word (0 on write/error), error
//   dmem (master modport)             : SCR1 dmem bus
// Optional macro SCR1_DMEM_INIT_TIMEOUT_EN: forces an error response after
// TIMEOUT_CYCLES cycles in WAIT_RESP; otherwise WAIT_RESP waits indefinitely.
// -----------------------------------------------------------------------------
module scr1_dmem_initiator
  import scr1_dmem_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  type_scr1_mem_width_e        cmd_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0] cmd_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0] cmd_wdata,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [SCR1_DMEM_DWIDTH-1:0] resp_rdata,
  output logic                        resp_err,
  scr1_dmem_initiator_if.master       dmem
);

  // The timeout counter is 16 bits; an out-of-range limit shows up as this
  // marker block in the elaborated hierarchy.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_cycles_out_of_range
  end

  type_scr1_dmem_init_fsm_e    state;
  type_scr1_dmem_init_fsm_e    state_next;

  logic                        cmd_write_q;
  type_scr1_mem_width_e        cmd_width_q;
  logic [SCR1_DMEM_AWIDTH-1:0] cmd_addr_q;
  logic [SCR1_DMEM_DWIDTH-1:0] cmd_wdata_q;
  logic [SCR1_DMEM_DWIDTH-1:0] rdata_q;
  logic                        err_q;

  logic                        cmd_misaligned;
  logic                        tmo_expired;

  assign cmd_misaligned = scr1_mem_addr_misaligned(cmd_width, cmd_addr[1:0]);

`ifdef SCR1_DMEM_INIT_TIMEOUT_EN
  logic tmo_clr;
  logic tmo_en;

  assign tmo_clr = (state == SCR1_DMEM_INIT_REQ) && dmem.dmem_req_ack;
  assign tmo_en  = (state == SCR1_DMEM_INIT_WAIT_RESP);

  scr1_dmem_init_tmo #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCR1_DMEM_INIT_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SCR1_DMEM_INIT_IDLE:
        if (cmd_valid) begin
          state_next = cmd_misaligned ? SCR1_DMEM_INIT_RESP_OUT : SCR1_DMEM_INIT_REQ;
        end
      SCR1_DMEM_INIT_REQ:
        if (dmem.dmem_req_ack) begin
          state_next = SCR1_DMEM_INIT_WAIT_RESP;
        end
      SCR1_DMEM_INIT_WAIT_RESP:
        if ((dmem.dmem_resp != SCR1_MEM_RESP_NOTRDY) || tmo_expired) begin
          state_next = SCR1_DMEM_INIT_RESP_OUT;
        end
      SCR1_DMEM_INIT_RESP_OUT:
        if (resp_ready) begin
          state_next = SCR1_DMEM_INIT_IDLE;
        end
      default: state_next = SCR1_DMEM_INIT_IDLE;
    endcase
  end

  // Handshake outputs come from the state register alone; bus and response
  // fields come straight from registers so they hold steady while waiting.
  always_comb begin
    cmd_ready       = (state == SCR1_DMEM_INIT_IDLE);
    resp_valid      = (state == SCR1_DMEM_INIT_RESP_OUT);
    dmem.dmem_req   = (state == SCR1_DMEM_INIT_REQ);
    dmem.dmem_cmd   = cmd_write_q ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
    dmem.dmem_width = cmd_width_q;
    dmem.dmem_addr  = cmd_addr_q;
    dmem.dmem_wdata = cmd_wdata_q;
    resp_rdata      = rdata_q;
    resp_err        = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_write_q <= 1'b0;
      cmd_width_q <= SCR1_MEM_WIDTH_WORD;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        SCR1_DMEM_INIT_IDLE:
          if (cmd_valid) begin
            cmd_write_q <= cmd_write;
            cmd_width_q <= cmd_width;
            cmd_addr_q  <= cmd_addr;
            cmd_wdata_q <= cmd_wdata;
            // A misaligned command is answered from here without a bus cycle.
            rdata_q     <= '0;
            err_q       <= cmd_misaligned;
          end
        SCR1_DMEM_INIT_WAIT_RESP:
          // A real response beats a timeout landing in the same cycle.
          case (dmem.dmem_resp)
            SCR1_MEM_RESP_RDY_OK: begin
              rdata_q <= cmd_write_q ? '0 : dmem.dmem_rdata;
              err_q   <= 1'b0;
            end
            SCR1_MEM_RESP_NOTRDY:
              if (tmo_expired) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
              end
            default: begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          endcase
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scr1_dmem_initiator.sv
// -----------------------------------------------------------------------------
// tb_scr1_dmem_initiator
// Directed and randomized transactions against scr1_dmem_initiator. The bench
// plays the dmem slave (configurable ack/response delays) and the client, and
// predicts latency, bus activity and response contents from the protocol
// rules with plain arithmetic. With SCR1_DMEM_INIT_TIMEOUT_EN defined the DUT
// is built with TIMEOUT_CYCLES=8 and timeout cases are added.
// -----------------------------------------------------------------------------
module tb_scr1_dmem_initiator;
  import scr1_dmem_initiator_pkg::*;

`ifdef SCR1_DMEM_INIT_TIMEOUT_EN
  localparam int TB_TMO = 8;
`else
  localparam int TB_TMO = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  type_scr1_mem_width_e cmd_width;
  logic [31:0]          cmd_addr;
  logic [31:0]          cmd_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [31:0]          resp_rdata;
  logic                 resp_err;

  int vectors = 0;
  int miscompares = 0;

  scr1_dmem_initiator_if dmem ();

  scr1_dmem_initiator #(
    .TIMEOUT_CYCLES ((TB_TMO > 0) ? TB_TMO : 256)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_width  (cmd_width),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dmem       (dmem.master)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transaction. ack_dly = extra REQ cycles before the ack,
  // resp_dly = NOTRDY cycles before the response, rdy_dly = cycles the client
  // holds resp_ready low. rk is the raw response code returned by the slave.
  task automatic run_txn(input logic wr, input type_scr1_mem_width_e w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int ack_dly, input int resp_dly,
                         input logic [1:0] rk, input logic [31:0] rd,
                         input int rdy_dly);
    bit          misaligned, timed_out, exp_err, acked, got, hold_ok, ready_ok;
    int          exp_wait, exp_req, exp_lat, cyc, lat, req_cycles, wait_n;
    logic [31:0] exp_rdata;
    type_scr1_mem_cmd_e exp_cmd;

    misaligned = ((w == SCR1_MEM_WIDTH_HWORD) && (a % 32'd2 != 32'd0)) ||
                 ((w == SCR1_MEM_WIDTH_WORD)  && (a % 32'd4 != 32'd0));
    exp_wait   = resp_dly + 1;
    timed_out  = (TB_TMO > 0) && (exp_wait > TB_TMO);
    if (timed_out) exp_wait = TB_TMO;
    exp_req    = misaligned ? 0 : ack_dly + 1;
    exp_lat    = misaligned ? 1 : exp_req + exp_wait + 1;
    exp_err    = misaligned || timed_out || (rk != 2'b01);
    exp_rdata  = (exp_err || wr) ? 32'd0 : rd;
    exp_cmd    = wr ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;

    @(negedge clk);
    check1("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_width = w;
    cmd_addr  = a;
    cmd_wdata = wd;

    cyc = 0; lat = 0; req_cycles = 0; wait_n = 0;
    acked = 0; got = 0; hold_ok = 1; ready_ok = 1;
    while (!got && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      cmd_valid = 1'b0;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      dmem.dmem_req_ack = 1'b0;
      dmem.dmem_resp    = SCR1_MEM_RESP_NOTRDY;
      dmem.dmem_rdata   = $urandom;
      if (resp_valid) begin
        got = 1;
        lat = cyc;
      end else begin
        if (cmd_ready) ready_ok = 0;
        if (dmem.dmem_req) begin
          if (dmem.dmem_addr !== a || dmem.dmem_wdata !== wd ||
              dmem.dmem_width !== w || dmem.dmem_cmd !== exp_cmd) hold_ok = 0;
          if (req_cycles == ack_dly) begin
            dmem.dmem_req_ack = 1'b1;
            acked = 1;
          end
          req_cycles++;
        end else if (acked) begin
          if (wait_n == resp_dly) begin
            dmem.dmem_resp  = type_scr1_mem_resp_e'(rk);
            dmem.dmem_rdata = rd;
          end
          wait_n++;
        end
      end
    end

    check1 ("resp_arrived",      got, 1'b1);
    check32("latency",           lat, exp_lat);
    check32("req_cycles",        req_cycles, exp_req);
    check1 ("req_fields_stable", hold_ok, 1'b1);
    check1 ("cmd_ready_busy",    ready_ok, 1'b1);
    check32("resp_rdata",        resp_rdata, exp_rdata);
    check1 ("resp_err",          resp_err, exp_err);

    // Back-pressure: late bus responses and new commands must not disturb it.
    for (int i = 0; i < rdy_dly; i++) begin
      dmem.dmem_resp  = SCR1_MEM_RESP_RDY_OK;
      dmem.dmem_rdata = $urandom;
      cmd_valid       = 1'b1;
      @(negedge clk);
      check1 ("stall_valid",     resp_valid, 1'b1);
      check32("stall_rdata",     resp_rdata, exp_rdata);
      check1 ("stall_err",       resp_err, exp_err);
      check1 ("stall_cmd_ready", cmd_ready, 1'b0);
    end
    dmem.dmem_resp = SCR1_MEM_RESP_NOTRDY;
    cmd_valid  = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
    resp_ready = 1'b0;
    check1("release_valid",     resp_valid, 1'b0);
    check1("release_cmd_ready", cmd_ready, 1'b1);
    check1("release_no_req",    dmem.dmem_req, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  wsel;
    logic [1:0]  rk;
    logic [31:0] ra;

    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_width = SCR1_MEM_WIDTH_WORD;
    cmd_addr = '0; cmd_wdata = '0; resp_ready = 1'b0;
    dmem.dmem_req_ack = 1'b0;
    dmem.dmem_rdata   = '0;
    dmem.dmem_resp    = SCR1_MEM_RESP_NOTRDY;

    // Reset values while rst_n is low
    #12;
    check1 ("rst_cmd_ready",  cmd_ready, 1'b1);
    check1 ("rst_dmem_req",   dmem.dmem_req, 1'b0);
    check1 ("rst_dmem_cmd",   dmem.dmem_cmd, 1'b0);
    check32("rst_dmem_width", 32'(dmem.dmem_width), 32'd2);
    check32("rst_dmem_addr",  dmem.dmem_addr, 32'd0);
    check32("rst_dmem_wdata", dmem.dmem_wdata, 32'd0);
    check1 ("rst_resp_valid", resp_valid, 1'b0);
    check32("rst_resp_rdata", resp_rdata, 32'd0);
    check1 ("rst_resp_err",   resp_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Timer-style read: same-cycle ack, next-cycle RDY_OK
    run_txn(1'b0, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0, 0, 0, 2'b01, 32'h1234_5678, 0);
    // Write with ack delayed 3 cycles
    run_txn(1'b1, SCR1_MEM_WIDTH_WORD, 32'h14, 32'hDEAD_BEEF, 3, 0, 2'b01, 32'h5555_AAAA, 0);
    // Misaligned commands, answered locally
    run_txn(1'b0, SCR1_MEM_WIDTH_WORD,  32'h06, 32'h0, 0, 0, 2'b01, 32'h1111_1111, 0);
    run_txn(1'b0, SCR1_MEM_WIDTH_HWORD, 32'h03, 32'h0, 0, 0, 2'b01, 32'h2222_2222, 0);
    // Bus error with resp_ready held low for 5 cycles
    run_txn(1'b0, SCR1_MEM_WIDTH_WORD, 32'h20, 32'h0, 0, 1, 2'b10, 32'h3333_3333, 5);
    // Illegal response encoding counts as an error
    run_txn(1'b0, SCR1_MEM_WIDTH_BYTE, 32'h21, 32'h0, 1, 2, 2'b11, 32'h4444_4444, 1);

    // Reset while in REQ: dmem_req must drop without waiting for a clock
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_width = SCR1_MEM_WIDTH_WORD; cmd_addr = 32'h40;
    @(negedge clk);
    cmd_valid = 1'b0;
    check1("req_before_reset", dmem.dmem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check1 ("rst_req_dmem_req",  dmem.dmem_req, 1'b0);
    check1 ("rst_req_cmd_ready", cmd_ready, 1'b1);
    check32("rst_req_dmem_addr", dmem.dmem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in WAIT_RESP; the late response afterwards must be dropped
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 32'h44;
    @(negedge clk);
    cmd_valid = 1'b0;
    dmem.dmem_req_ack = 1'b1;
    @(negedge clk);
    dmem.dmem_req_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    check1("rst_wait_dmem_req",   dmem.dmem_req, 1'b0);
    check1("rst_wait_resp_valid", resp_valid, 1'b0);
    check1("rst_wait_cmd_ready",  cmd_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    dmem.dmem_resp  = SCR1_MEM_RESP_RDY_OK;
    dmem.dmem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("late_resp_valid", resp_valid, 1'b0);
      check1("late_dmem_req",   dmem.dmem_req, 1'b0);
      check1("late_cmd_ready",  cmd_ready, 1'b1);
    end
    dmem.dmem_resp = SCR1_MEM_RESP_NOTRDY;

    if (TB_TMO > 0) begin
      // Slave never answers, then answers exactly on the last allowed cycle
      run_txn(1'b0, SCR1_MEM_WIDTH_WORD, 32'h30, 32'h0, 0, 1000, 2'b01, 32'h7777_7777, 0);
      run_txn(1'b0, SCR1_MEM_WIDTH_WORD, 32'h30, 32'h0, 1, TB_TMO - 1, 2'b01, 32'h8888_8888, 0);
    end

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      wsel = 2'($urandom_range(0, 2));
      case ($urandom_range(0, 4))
        3:       rk = 2'b10;
        4:       rk = 2'b11;
        default: rk = 2'b01;
      endcase
      ra = 32'($urandom_range(0, 255));
      run_txn(1'($urandom_range(0, 1)), type_scr1_mem_width_e'(wsel), ra, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), rk, $urandom,
              $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
